// File: rtl/round_robin_arbiter8.sv
// round_robin_arbiter8
//   Eight-way round-robin arbiter with a programmable hold limit. The winner is
//   reported both as a 3-bit index and as a registered one-hot grant vector.
//
// Parameters:
//   MAX_HOLD  - maximum consecutive cycles a single grant may be held (1..15)
// Ports:
//   clk       - rising-edge clock
//   rst       - asynchronous active-high reset
//   en        - arbitration enable; 0 releases any grant and blocks new ones
//   req[7:0]  - request vector, bit n is requester n
//   gnt[7:0]  - registered one-hot grant (zero when no grant is active)
//   gnt_idx   - registered index of the current or last winner
//   gnt_valid - registered flag, a grant is active
module round_robin_arbiter8 #(
    parameter int unsigned MAX_HOLD = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [7:0] req,
    output logic [7:0] gnt,
    output logic [2:0] gnt_idx,
    output logic       gnt_valid
);

    typedef enum logic {StIdle, StGrant} state_e;

    state_e     state_q, state_d;
    logic [2:0] ptr_q, ptr_d;
    logic [3:0] hold_cnt_q, hold_cnt_d;
    logic [2:0] gnt_idx_q, gnt_idx_d;
    logic [7:0] gnt_q, gnt_d;

    logic        release_grant;
    logic [2:0]  search_ptr;
    logic [15:0] req_dbl;
    logic [15:0] req_rot;
    logic [2:0]  win_off;
    logic [2:0]  win_idx;

    // A held grant ends when its requester drops, the hold limit is hit, or
    // arbitration is disabled.
    assign release_grant = !req[gnt_idx_q] || (hold_cnt_q == 4'(MAX_HOLD)) || !en;

    // On release the search starts just past the released requester, so it
    // is examined last and wins again only when nobody else is asking.
    always_comb begin
        search_ptr = ptr_q;
        if (state_q == StGrant && release_grant) begin
            search_ptr = gnt_idx_q + 3'd1;
        end
    end

    // Rotate so the search pointer lands on bit 0, then take the lowest set bit.
    always_comb begin
        req_dbl = {req, req};
        req_rot = req_dbl >> search_ptr;
        win_off = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (req_rot[i]) begin
                win_off = 3'(i);
            end
        end
        win_idx = search_ptr + win_off;
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            ptr_q      <= 3'd0;
            hold_cnt_q <= 4'd0;
            gnt_idx_q  <= 3'd0;
            gnt_q      <= 8'd0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            hold_cnt_q <= hold_cnt_d;
            gnt_idx_q  <= gnt_idx_d;
            gnt_q      <= gnt_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        hold_cnt_d = hold_cnt_q;
        gnt_idx_d  = gnt_idx_q;

        unique case (state_q)
            StIdle: begin
                if (en && (req != 8'd0)) begin
                    state_d    = StGrant;
                    gnt_idx_d  = win_idx;
                    hold_cnt_d = 4'd1;
                end
            end
            StGrant: begin
                if (release_grant) begin
                    ptr_d = gnt_idx_q + 3'd1;
                    if (en && (req != 8'd0)) begin
                        gnt_idx_d  = win_idx;
                        hold_cnt_d = 4'd1;
                    end else begin
                        state_d    = StIdle;
                        hold_cnt_d = 4'd0;
                    end
                end else begin
                    hold_cnt_d = hold_cnt_q + 4'd1;
                end
            end
            default: state_d = StIdle;
        endcase

        // Grant vector is registered alongside the index so no decode sits
        // between the flops and the datapath select.
        gnt_d = (state_d == StGrant) ? (8'd1 << gnt_idx_d) : 8'd0;
    end

    // Output logic
    always_comb begin
        gnt       = gnt_q;
        gnt_idx   = gnt_idx_q;
        gnt_valid = (state_q == StGrant);
    end

endmodule

// File: tb/tb_round_robin_arbiter8.sv
module tb_round_robin_arbiter8;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [7:0] req;
    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       gnt_valid;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic       en;
        logic [7:0] req;
        logic [7:0] gnt;
        logic [2:0] idx;
        logic       valid;
    } vec_t;

    vec_t vecs[$];

    round_robin_arbiter8 #(.MAX_HOLD(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .req       (req),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic e, input logic [7:0] r, input logic [7:0] g,
                       input logic [2:0] i, input logic v);
        vec_t t;
        t.en = e; t.req = r; t.gnt = g; t.idx = i; t.valid = v;
        vecs.push_back(t);
    endtask

    task automatic chk_out(input string name, input logic [7:0] g, input logic [2:0] i,
                           input logic v);
        chk({name, ".gnt"}, 32'(gnt), 32'(g));
        chk({name, ".idx"}, 32'(gnt_idx), 32'(i));
        chk({name, ".valid"}, 32'(gnt_valid), 32'(v));
    endtask

    initial begin
        // Single short request: 5 granted for 2 cycles, ptr -> 6
        add(1, 8'h20, 8'h20, 3'd5, 1);
        add(1, 8'h20, 8'h20, 3'd5, 1);
        add(1, 8'h00, 8'h00, 3'd5, 0);
        // Grant 6 so ptr -> 7, then wrap: 7 first, 0 after 7 releases
        add(1, 8'h40, 8'h40, 3'd6, 1);
        add(1, 8'h00, 8'h00, 3'd6, 0);
        add(1, 8'h81, 8'h80, 3'd7, 1);
        add(1, 8'h01, 8'h01, 3'd0, 1);
        add(1, 8'h00, 8'h00, 3'd0, 0);
        // Enable drop with 2 active; ptr -> 3, then 0 wins on re-enable
        add(1, 8'h04, 8'h04, 3'd2, 1);
        add(0, 8'h04, 8'h00, 3'd2, 0);
        add(0, 8'h05, 8'h00, 3'd2, 0);
        add(0, 8'h05, 8'h00, 3'd2, 0);
        add(1, 8'h05, 8'h01, 3'd0, 1);
        add(1, 8'h05, 8'h01, 3'd0, 1);
        add(1, 8'h05, 8'h01, 3'd0, 1);
        add(1, 8'h05, 8'h01, 3'd0, 1);
        // Hold limit reached: back-to-back hand-off to 2
        add(1, 8'h05, 8'h04, 3'd2, 1);
        add(1, 8'h00, 8'h00, 3'd2, 0);
        // Sole requester 3 held 10 cycles: re-granted with no gap
        for (int k = 0; k < 10; k++) add(1, 8'h08, 8'h08, 3'd3, 1);
        add(1, 8'h00, 8'h00, 3'd3, 0);

        rst = 1'b1;
        en  = 1'b0;
        req = 8'h00;
        #12;
        chk_out("reset", 8'h00, 3'd0, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[n]) begin
            @(negedge clk);
            en  = vecs[n].en;
            req = vecs[n].req;
            @(posedge clk);
            #1;
            chk_out($sformatf("vec%0d", n), vecs[n].gnt, vecs[n].idx, vecs[n].valid);
        end

        // Asynchronous reset in the middle of a grant to requester 4
        @(negedge clk);
        en  = 1'b1;
        req = 8'h10;
        @(posedge clk);
        #1;
        chk_out("pre_rst", 8'h10, 3'd4, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        chk_out("async_rst", 8'h00, 3'd0, 1'b0);

        // Full load after reset: 0..7,0 each for exactly 4 cycles
        @(negedge clk);
        rst = 1'b0;
        req = 8'hFF;
        for (int c = 0; c < 36; c++) begin
            logic [2:0] ei;
            ei = 3'((c / 4) % 8);
            @(posedge clk);
            #1;
            chk_out($sformatf("full%0d", c), 8'd1 << ei, ei, 1'b1);
            @(negedge clk);
        end

        req = 8'h00;
        @(posedge clk);
        #1;
        chk_out("full_end", 8'h00, 3'd0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
